// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the handshaked ALU / multiply-divide unit.
//   alu_op_e    - 5-bit operation codes (bit 4 set = M-extension group)
//   alu_state_e - control state machine states
//   SHAMT_W     - shift-amount width for the default 32-bit datapath
package alu_pkg;

    localparam int ALU_DW  = 32;
    localparam int SHAMT_W = $clog2(ALU_DW);

    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_XOR    = 5'b00011,
        OP_SLL    = 5'b00100,
        OP_SLTU   = 5'b00101,
        OP_SUB    = 5'b00110,
        OP_SUBU   = 5'b00111,
        OP_SRL    = 5'b01000,
        OP_SLT    = 5'b01010,
        OP_SRA    = 5'b01100,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mdu_iter.sv
// mdu_iter: iterative multiply/divide datapath.
//   One 2*DATA_WIDTH register serves as shift-add product accumulator or as
//   restoring-divide {remainder, quotient} register. Operands are reduced to
//   magnitudes on start; the sign is re-applied combinationally on the output.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   i_start          capture operands and perform the first iteration
//   i_step           perform one further iteration
//   i_op             low 3 bits of the M-group opcode
//   i_a, i_b         operands (only sampled on i_start)
//   o_result         sign-corrected result of the selected half
module mdu_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_step,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int W = DATA_WIDTH;

    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_m;
    logic [2:0]     r_op;
    logic           r_neg;

    logic           w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
    logic [W-1:0]   w_a_mag, w_b_mag;
    logic [2*W-1:0] w_src, w_nxt, w_mul_nxt, w_div_nxt, w_prod;
    logic [W-1:0]   w_m, w_qr;
    logic           w_div, w_ge;
    logic [W:0]     w_sum, w_rsh, w_diff;

    // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed
    assign w_a_sgn = (i_op == 3'b001) | (i_op == 3'b010) | (i_op == 3'b100) | (i_op == 3'b110);
    assign w_b_sgn = (i_op == 3'b001) | (i_op == 3'b100) | (i_op == 3'b110);
    assign w_a_neg = w_a_sgn & i_a[W-1];
    assign w_b_neg = w_b_sgn & i_b[W-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;
    // remainder follows the dividend's sign, everything else the product sign
    assign w_neg   = (i_op[2] & i_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    // the first iteration is folded into the start cycle
    assign w_src = i_start ? {{W{1'b0}}, w_a_mag} : r_acc;
    assign w_m   = i_start ? w_b_mag : r_m;
    assign w_div = i_start ? i_op[2] : r_op[2];

    // shift-add: add multiplicand into the upper half on LSB, shift right with carry
    assign w_sum     = {1'b0, w_src[2*W-1:W]} + (w_src[0] ? {1'b0, w_m} : {(W+1){1'b0}});
    assign w_mul_nxt = {w_sum, w_src[W-1:1]};

    // restoring divide: shift left, trial-subtract divisor from the W+1 bit partial remainder
    assign w_rsh     = w_src[2*W-1:W-1];
    assign w_diff    = w_rsh - {1'b0, w_m};
    assign w_ge      = ~w_diff[W];
    assign w_div_nxt = {(w_ge ? w_diff[W-1:0] : w_rsh[W-1:0]), w_src[W-2:0], w_ge};

    assign w_nxt = w_div ? w_div_nxt : w_mul_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_m   <= '0;
            r_op  <= '0;
            r_neg <= 1'b0;
        end else if (i_start) begin
            r_acc <= w_nxt;
            r_m   <= w_b_mag;
            r_op  <= i_op;
            r_neg <= w_neg;
        end else if (i_step) begin
            r_acc <= w_nxt;
        end
    end

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_qr   = r_op[1] ? r_acc[2*W-1:W] : r_acc[W-1:0];

    always_comb begin
        o_result = '0;
        if (r_op[2])
            o_result = r_neg ? -w_qr : w_qr;
        else if (r_op[1:0] == 2'b00)
            o_result = w_prod[W-1:0];
        else
            o_result = w_prod[2*W-1:W];
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered valid/ready ALU with RV32M multiply/divide.
//   Base ops, unknown codes and divide special cases (divisor 0, MIN / -1)
//   finish in one cycle; multiply/divide iterate over DATA_WIDTH cycles in
//   mdu_iter. Define ALU_FAST_MUL_EN to make multiplies single-cycle with a
//   combinational 2*DATA_WIDTH product; divide stays iterative either way.
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   in_valid / in_ready       request handshake (SrcA, SrcB, Operation)
//   out_valid / out_ready     result handshake (ALUResult, Con_BLT, Con_BGT, zero)
module alu_mdu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     Con_BLT,
    output logic                     Con_BGT,
    output logic                     zero
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};

    alu_state_e    r_state, w_state_nxt;
    logic [SW-1:0] r_cnt;
    logic [W-1:0]  r_res;
    logic          r_blt, r_bgt, r_zero;

    logic          w_accept, w_is_m, w_is_div, w_div0, w_ovf, w_special, w_iter;
    logic          w_step, w_last;
    logic [W-1:0]  w_res, w_mdu_res;
    logic          w_blt, w_bgt, w_zero;
    logic [SW-1:0] w_shamt;

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == DONE);
    assign ALUResult = r_res;
    assign Con_BLT   = r_blt;
    assign Con_BGT   = r_bgt;
    assign zero      = r_zero;

    // only 10xxx is the M group; 11xxx codes are unknown and take the base path
    assign w_is_m    = (Operation[4:3] == 2'b10);
    assign w_is_div  = w_is_m & Operation[2];
    assign w_div0    = (SrcB == '0);
    assign w_ovf     = ~Operation[0] & (SrcA == MIN_S) & (&SrcB);
    assign w_special = w_is_div & (w_div0 | w_ovf);
`ifdef ALU_FAST_MUL_EN
    assign w_iter    = w_is_div & ~w_special;
`else
    assign w_iter    = w_is_m & ~w_special;
`endif

    assign w_step = (r_state == BUSY) && (r_cnt != '0);
    assign w_last = (r_state == BUSY) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_nxt = w_iter ? BUSY : DONE;
            BUSY: if (r_cnt == '0) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = in_valid ? (w_iter ? BUSY : DONE) : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef ALU_FAST_MUL_EN
    logic           w_fa_sgn, w_fb_sgn;
    logic [2*W-1:0] w_fa, w_fb, w_fp;
    // sign-extend to 2W so the low 2W bits of the product are the exact signed product
    assign w_fa_sgn = (Operation[1:0] == 2'b01) | (Operation[1:0] == 2'b10);
    assign w_fb_sgn = (Operation[1:0] == 2'b01);
    assign w_fa     = {{W{w_fa_sgn & SrcA[W-1]}}, SrcA};
    assign w_fb     = {{W{w_fb_sgn & SrcB[W-1]}}, SrcB};
    assign w_fp     = w_fa * w_fb;
`endif

    assign w_shamt = SrcB[SW-1:0];

    always_comb begin
        w_res  = '0;
        w_blt  = 1'b0;
        w_bgt  = 1'b0;
        w_zero = 1'b0;
        if (w_special) begin
            if (Operation[1]) w_res = w_div0 ? SrcA : '0;
            else              w_res = w_div0 ? '1 : MIN_S;
        end else begin
            case (Operation)
                OP_AND:  w_res = SrcA & SrcB;
                OP_OR:   w_res = SrcA | SrcB;
                OP_XOR:  w_res = SrcA ^ SrcB;
                OP_ADD:  w_res = SrcA + SrcB;
                OP_SUB: begin
                    w_res  = SrcA - SrcB;
                    w_blt  = $signed(SrcA) < $signed(SrcB);
                    w_bgt  = $signed(SrcA) > $signed(SrcB);
                    w_zero = (SrcA == SrcB);
                end
                OP_SUBU: begin
                    w_res  = SrcA - SrcB;
                    w_blt  = SrcA < SrcB;
                    w_bgt  = SrcA > SrcB;
                    w_zero = (SrcA == SrcB);
                end
                OP_SLTU: w_res = {{(W-1){1'b0}}, (SrcA < SrcB)};
                OP_SLT:  w_res = {{(W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
                OP_SLL:  w_res = SrcA << w_shamt;
                OP_SRL:  w_res = SrcA >> w_shamt;
                OP_SRA:  w_res = $unsigned($signed(SrcA) >>> w_shamt);
`ifdef ALU_FAST_MUL_EN
                OP_MUL:    w_res = w_fp[W-1:0];
                OP_MULH,
                OP_MULHSU,
                OP_MULHU:  w_res = w_fp[2*W-1:W];
`endif
                default: w_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_res  <= '0;
            r_blt  <= 1'b0;
            r_bgt  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_iter) begin
                    r_cnt <= SW'(W - 1);
                end else begin
                    r_res  <= w_res;
                    r_blt  <= w_blt;
                    r_bgt  <= w_bgt;
                    r_zero <= w_zero;
                end
            end else if (w_step) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last) begin
                r_res  <= w_mdu_res;
                r_blt  <= 1'b0;
                r_bgt  <= 1'b0;
                r_zero <= 1'b0;
            end
        end
    end

    mdu_iter #(.DATA_WIDTH(W)) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_accept & w_iter),
        .i_step   (w_step),
        .i_op     (Operation[2:0]),
        .i_a      (SrcA),
        .i_b      (SrcB),
        .o_result (w_mdu_res)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: table-driven check of alu_mdu plus hand sequences for
// back-pressure hold, back-to-back base ops and reset during BUSY.
module tb_alu_mdu;
    import alu_pkg::*;

`ifdef ALU_FAST_MUL_EN
    localparam int LM = 1;
`else
    localparam int LM = 33;
`endif
    localparam int LD = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic [4:0]  Operation = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALUResult;
    logic        Con_BLT, Con_BGT, zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mdu #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
        .out_ready(out_ready), .ALUResult(ALUResult), .Con_BLT(Con_BLT),
        .Con_BGT(Con_BGT), .zero(zero)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, res;
        logic        blt, bgt, z;
        int          lat;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic blt, input logic bgt,
                       input logic z, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res;
        v.blt = blt; v.bgt = bgt; v.z = z; v.lat = lat;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic wait_ready(input int idx);
        int g = 0;
        while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
        if (!in_ready) chk("ready_timeout", idx, 32'(in_ready), 32'd1);
    endtask

    // issue one op, drop in_valid and scramble operands after accept, measure latency
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input int idx, output int lat);
        wait_ready(idx);
        in_valid = 1'b1; SrcA = a; SrcB = b; Operation = op;
        @(posedge clk); #1;
        in_valid = 1'b0; SrcA = 32'hDEADBEEF; SrcB = 32'h0BADF00D; Operation = OP_ADD;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (lat == 2 && exp_lat > 1) chk("busy_in_ready", idx, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit seen;

        // logic ops
        add(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1);
        add(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 1);
        add(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 1);
        add(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 0, 1);
        // compares
        add(OP_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 1, 0, 0, 1);
        add(OP_SUB,  32'd2,        32'hFFFFFFFF, 32'd3,        0, 1, 0, 1);
        add(OP_SUB,  32'd9,        32'd9,        32'd0,        0, 0, 1, 1);
        add(OP_SUBU, 32'd3,        32'd3,        32'd0,        0, 0, 1, 1);
        add(OP_SUBU, 32'd2,        32'hFFFFFFFF, 32'd3,        1, 0, 0, 1);
        add(OP_SUBU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFD, 0, 1, 0, 1);
        add(OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 0, 1);
        add(OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 0, 0, 1);
        add(OP_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        0, 0, 0, 1);
        // shifts, amount masked to 5 bits
        add(OP_SLL,  32'd1,        32'h00000024, 32'h00000010, 0, 0, 0, 1);
        add(OP_SRL,  32'h80000000, 32'd4,        32'h08000000, 0, 0, 0, 1);
        add(OP_SRA,  32'h80000000, 32'd4,        32'hF8000000, 0, 0, 0, 1);
        add(OP_SRA,  32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 0, 0, 0, 1);
        // unknown codes
        add(5'b01111, 32'd5,       32'd3,        32'd0,        0, 0, 0, 1);
        add(5'b11000, 32'd5,       32'd3,        32'd0,        0, 0, 0, 1);
        add(5'b11100, 32'd5,       32'd0,        32'd0,        0, 0, 0, 1);
        // multiplies
        add(OP_MUL,    32'd6,        32'd7,        32'h0000002A, 0, 0, 0, LM);
        add(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, LM);
        add(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 0, LM);
        add(OP_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, 0, 0, LM);
        add(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, LM);
        add(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, LM);
        // divide special cases
        add(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, 1);
        add(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 1);
        add(OP_DIVU, 32'd7,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 1);
        add(OP_REMU, 32'd7,        32'd0,        32'd7,        0, 0, 0, 1);
        add(OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 1);
        add(OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 0, 0, 0, 1);
        // iterative divides
        add(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 0, LD);
        add(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0, 0, LD);
        add(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 0, LD);
        add(OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        0, 0, 0, LD);
        add(OP_DIVU, 32'd100,      32'd7,        32'd14,       0, 0, 0, LD);
        add(OP_REMU, 32'd100,      32'd7,        32'd2,        0, 0, 0, LD);
        add(OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 0, 0, 0, LD);
        add(OP_REMU, 32'hFFFFFFFF, 32'd10,       32'd5,        0, 0, 0, LD);
        add(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 0, 0, LD);
        add(OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 0, LD);

        // reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_in_ready",  0, 32'(in_ready),  32'd1);
        chk("rst_result",    0, ALUResult,      32'd0);
        chk("rst_flags",     0, {29'd0, Con_BLT, Con_BGT, zero}, 32'd0);

        foreach (tv[i]) begin
            issue(tv[i].op, tv[i].a, tv[i].b, tv[i].lat, i, lat);
            chk("latency", i, 32'(lat),       32'(tv[i].lat));
            chk("result",  i, ALUResult,      tv[i].res);
            chk("blt",     i, 32'(Con_BLT),   32'(tv[i].blt));
            chk("bgt",     i, 32'(Con_BGT),   32'(tv[i].bgt));
            chk("zero",    i, 32'(zero),      32'(tv[i].z));
        end

        // back-to-back base ops with out_ready held: one result per cycle
        wait_ready(100);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; Operation = OP_ADD; SrcA = 32'(k * 16); SrcB = 32'd3;
            @(posedge clk); #1;
            chk("b2b_valid",  k, 32'(out_valid), 32'd1);
            chk("b2b_result", k, ALUResult, 32'(k * 16 + 3));
        end
        in_valid = 1'b0;

        // back-pressure: DIV -7/2 result holds while out_ready is low
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, LD, 200, lat);
        chk("hold_latency", 200, 32'(lat), 32'd33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_valid",    k, 32'(out_valid), 32'd1);
            chk("hold_result",   k, ALUResult,      32'hFFFFFFFD);
            chk("hold_in_ready", k, 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", 200, 32'(out_valid), 32'd0);

        // reset mid-BUSY: aborted operation never produces a result
        wait_ready(300);
        in_valid = 1'b1; Operation = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", 300, 32'(in_ready), 32'd1);
        chk("abort_result",   300, ALUResult,     32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 300, 32'(seen), 32'd0);

        // unit still works after the abort
        issue(OP_REM, 32'hFFFFFFF9, 32'd2, LD, 301, lat);
        chk("post_abort_lat", 301, 32'(lat), 32'd33);
        chk("post_abort_res", 301, ALUResult, 32'hFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
